// File: rtl/mul_div_unit_pkg.sv
// Shared ISA constants for the HI/LO multiply/divide unit: funct codes,
// FSM state encodings and small funct-decode helpers.
package mul_div_unit_pkg;

  // ISA funct codes handled by the HI/LO unit
  localparam logic [5:0] FUN_MTHI  = 6'h11;
  localparam logic [5:0] FUN_MTLO  = 6'h13;
  localparam logic [5:0] FUN_MULT  = 6'h18;
  localparam logic [5:0] FUN_MULTU = 6'h19;
  localparam logic [5:0] FUN_DIV   = 6'h1A;
  localparam logic [5:0] FUN_DIVU  = 6'h1B;

  // FSM state encodings (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  typedef logic [1:0] state_t;

  // True for the four iterative operations
  function automatic logic fun_is_muldiv(input logic [5:0] f);
    return (f == FUN_MULT) || (f == FUN_MULTU) || (f == FUN_DIV) || (f == FUN_DIVU);
  endfunction

  // True for the divide flavours
  function automatic logic fun_is_div(input logic [5:0] f);
    return (f == FUN_DIV) || (f == FUN_DIVU);
  endfunction

  // True for the signed flavours, whose operands are taken as magnitudes
  function automatic logic fun_is_signed(input logic [5:0] f);
    return (f == FUN_MULT) || (f == FUN_DIV);
  endfunction

endpackage

// File: rtl/mul_div_core.sv
// Iterative datapath: one shift-add multiply step or one restoring-divide
// step per enabled cycle on unsigned magnitudes. A single 2*WIDTH
// accumulator serves both: {partial product, multiplier} for MUL and
// {remainder, dividend/quotient} for DIV.
module mul_div_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               load_div,
  input  logic               step,
  input  logic [WIDTH-1:0]   opa_abs,
  input  logic [WIDTH-1:0]   opb_abs,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [CW-1:0]      cnt_r;
  logic               div_mode_r;

  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_ge_s;
  logic [2*WIDTH-1:0] div_next_s;

  // Next accumulator value for one multiply step and one divide step
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};

    div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    // only meaningful when div_ge_s, where the true difference fits WIDTH bits
    div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
    if (div_ge_s) begin
      div_next_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Load operands on accept, otherwise advance one iteration per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= {(2*WIDTH){1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      div_mode_r <= 1'b0;
    end else if (load) begin
      acc_r      <= load_div ? {{WIDTH{1'b0}}, opa_abs} : {{WIDTH{1'b0}}, opb_abs};
      opnd_r     <= load_div ? opb_abs : opa_abs;
      cnt_r      <= {CW{1'b0}};
      div_mode_r <= load_div;
    end else if (step) begin
      acc_r      <= div_mode_r ? div_next_s : mul_next_s;
      cnt_r      <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign acc  = acc_r;
  assign last = (cnt_r == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: FSM, sign handling, start/busy/done handshake
// and the architectural HI/LO registers. The iterative arithmetic lives in
// mul_div_core and always works on unsigned magnitudes; the FIX state
// restores signs and handles divide-by-zero before writing HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Two's-complement negation at operand width
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation at product width
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r;
  state_t             next_state_s;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               div_zero_r;
  logic               fix_div_r;
  logic [WIDTH-1:0]   raw_a_r;

  logic               idle_s;
  logic               req_s;
  logic               accept_s;
  logic               is_div_s;
  logic               sa_s;
  logic               sb_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic               step_s;
  logic               last_s;
  logic [2*WIDTH-1:0] acc_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  // Request decode and operand magnitudes; flush always beats start
  always_comb begin
    idle_s   = (state_r == ST_IDLE);
    req_s    = idle_s && start && !flush;
    accept_s = req_s && fun_is_muldiv(funct);
    is_div_s = fun_is_div(funct);
    sa_s     = fun_is_signed(funct) && opA[WIDTH-1];
    sb_s     = fun_is_signed(funct) && opB[WIDTH-1];
    if (sa_s) begin
      a_abs_s = neg_w(opA);
    end else begin
      a_abs_s = opA;
    end
    if (sb_s) begin
      b_abs_s = neg_w(opB);
    end else begin
      b_abs_s = opB;
    end
    step_s   = ((state_r == ST_MUL) || (state_r == ST_DIV)) && !flush;
  end

  mul_div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rstN),
    .load     (accept_s),
    .load_div (is_div_s),
    .step     (step_s),
    .opa_abs  (a_abs_s),
    .opb_abs  (b_abs_s),
    .acc      (acc_s),
    .last     (last_s)
  );

  // Sign restoration and divide-by-zero substitution for the FIX write
  always_comb begin
    if (neg_q_r) begin
      prod_s = neg_2w(acc_s);
    end else begin
      prod_s = acc_s;
    end
    if (div_zero_r) begin
      quo_s = {WIDTH{1'b1}};
      rem_s = raw_a_r;
    end else begin
      quo_s = neg_q_r ? neg_w(acc_s[WIDTH-1:0]) : acc_s[WIDTH-1:0];
      rem_s = neg_r_r ? neg_w(acc_s[2*WIDTH-1:WIDTH]) : acc_s[2*WIDTH-1:WIDTH];
    end
  end

  // FSM next-state: IDLE -> MUL|DIV for WIDTH steps -> FIX -> IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = is_div_s ? ST_DIV : ST_MUL;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_s) begin
          next_state_s = ST_FIX;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_FIX:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State and handshake registers; flush aborts without a done pulse
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (flush) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
      done_r  <= (state_r == ST_FIX);
    end
  end

  // Capture result-sign flags and divide-by-zero info when an op is accepted
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      fix_div_r  <= 1'b0;
      raw_a_r    <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      neg_q_r    <= sa_s ^ sb_s;
      neg_r_r    <= is_div_s && sa_s;
      div_zero_r <= is_div_s && (opB == {WIDTH{1'b0}});
      fix_div_r  <= is_div_s;
      raw_a_r    <= opA;
    end
  end

  // HI/LO architectural registers: written only by MTHI/MTLO or the FIX cycle
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if ((state_r == ST_FIX) && !flush) begin
      if (fix_div_r) begin
        hi_r <= rem_s;
        lo_r <= quo_s;
      end else begin
        hi_r <= prod_s[2*WIDTH-1:WIDTH];
        lo_r <= prod_s[WIDTH-1:0];
      end
    end else if (req_s && (funct == FUN_MTHI)) begin
      hi_r <= opA;
    end else if (req_s && (funct == FUN_MTLO)) begin
      lo_r <= opA;
    end
  end

`ifndef SYNTHESIS
  // Simulation aid: report start requests carrying a funct this unit ignores
  always @(posedge clk) begin
    if (rstN && req_s && !fun_is_muldiv(funct) && (funct != FUN_MTHI) &&
        (funct != FUN_MTLO) && !$isunknown(funct)) begin
      $warning("mul_div_unit: ignoring start with funct 0x%02h", funct);
    end
  end
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit. Inputs change just after
// the rising edge or on the falling edge; outputs are sampled 1 time unit
// after the rising edge.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rstN  (rstN),
    .start (start),
    .funct (funct),
    .opA   (opA),
    .opB   (opB),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for done; done_cyc=0 means timeout
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int busy_cyc);
    @(negedge clk);
    funct = f; opA = a; opB = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cyc = busy ? 1 : 0;
    done_cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0; flush = 1'b0; funct = 6'h00; opA = 32'h0; opB = 32'h0;
    repeat (2) @(negedge clk);
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mthi_mtlo();
    int busy_seen;
    busy_seen = 0;
    @(negedge clk);
    funct = FUN_MTHI; opA = 32'h0000_1234; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (busy) busy_seen++;
    total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL mthi_hi got=%h exp=%h", hi, 32'h1234); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL mthi_lo got=%h exp=%h", lo, 32'h0); end
    @(negedge clk);
    funct = FUN_MTLO; opA = 32'h0000_5678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (busy) busy_seen++;
    total++; if (lo !== 32'h0000_5678) begin bad++; $display("FAIL mtlo_lo got=%h exp=%h", lo, 32'h5678); end
    total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL mtlo_hi got=%h exp=%h", hi, 32'h1234); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mtx_done got=%b exp=0", done); end
    @(posedge clk);
    #1 if (busy) busy_seen++;
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL mtx_busy got=%0d exp=0", busy_seen); end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    funct = FUN_DIV; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL midreset_hi got=%h exp=%h", hi, 32'h0); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL midreset_lo got=%h exp=%h", lo, 32'h0); end
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_idle got=%b%b exp=00", busy, done); end
  endtask

  task automatic test_multu();
    int dc, bc;
    run_op(FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc);
    total++; if (dc !== 33) begin bad++; $display("FAIL multu_latency got=%0d exp=33", dc); end
    total++; if (bc !== 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=%h", hi, 32'hFFFF_FFFE); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=%h", lo, 32'h1); end
    @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mult();
    int dc, bc;
    run_op(FUN_MULT, 32'hFFFF_FFFD, 32'd7, dc, bc);
    total++; if (dc !== 33) begin bad++; $display("FAIL mult_latency got=%0d exp=33", dc); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=%h", hi, 32'hFFFF_FFFF); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h exp=%h", lo, 32'hFFFF_FFEB); end
  endtask

  task automatic test_div();
    int dc, bc;
    run_op(FUN_DIV, 32'hFFFF_FFF9, 32'd2, dc, bc);
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=%h", lo, 32'hFFFF_FFFD); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=%h", hi, 32'hFFFF_FFFF); end
    run_op(FUN_DIVU, 32'd100, 32'd7, dc, bc);
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=%h", lo, 32'd14); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=%h", hi, 32'd2); end
    run_op(FUN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dc, bc);
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo got=%h exp=%h", lo, 32'h8000_0000); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL divovf_hi got=%h exp=%h", hi, 32'h0); end
  endtask

  task automatic test_div_zero();
    int dc, bc;
    run_op(FUN_DIVU, 32'd5, 32'd0, dc, bc);
    total++; if (dc !== 33) begin bad++; $display("FAIL div0_latency got=%0d exp=33", dc); end
    total++; if (bc !== 33) begin bad++; $display("FAIL div0_busy_cycles got=%0d exp=33", bc); end
    total++; if (hi !== 32'd5) begin bad++; $display("FAIL div0_hi got=%h exp=%h", hi, 32'd5); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo got=%h exp=%h", lo, 32'hFFFF_FFFF); end
  endtask

  task automatic test_flush();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    funct = FUN_MULT; opA = 32'd3; opB = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(posedge clk);
      #1;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL flush_done got=%0d exp=0", done_seen); end
    total++; if (hi !== 32'd5) begin bad++; $display("FAIL flush_hi got=%h exp=%h", hi, 32'd5); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL flush_lo got=%h exp=%h", lo, 32'hFFFF_FFFF); end
    // flush and start together in IDLE: start must be dropped
    @(negedge clk);
    funct = FUN_MTHI; opA = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    total++; if (hi !== 32'd5) begin bad++; $display("FAIL flushstart_hi got=%h exp=%h", hi, 32'd5); end
    @(negedge clk);
    funct = FUN_MULTU; opA = 32'd9; opB = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flushstart_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int dc;
    dc = 0;
    @(negedge clk);
    funct = FUN_DIVU; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(posedge clk);
    // a second request held for a few busy cycles must be ignored
    #1 funct = FUN_MULTU; opA = 32'hFFFF_FFFF; opB = 32'd3;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) start = 1'b0;
      if (done) begin
        dc = i;
        break;
      end
    end
    start = 1'b0;
    total++; if (dc !== 33) begin bad++; $display("FAIL b2b_latency got=%0d exp=33", dc); end
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL b2b_lo got=%h exp=%h", lo, 32'd14); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL b2b_hi got=%h exp=%h", hi, 32'd2); end
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_bad_funct();
    @(negedge clk);
    funct = 6'h20; opA = 32'h1111_1111; opB = 32'h2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL badfunct_busy got=%b exp=0", busy); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL badfunct_hi got=%h exp=%h", hi, 32'd2); end
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL badfunct_lo got=%h exp=%h", lo, 32'd14); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mthi_mtlo();
    test_reset_mid_div();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_bad_funct();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle HI/LO multiply/divide unit for the MIPS datapath. It sits beside the single-cycle ALU in the execute stage and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. It owns the HI/LO architectural registers and drives them to the MFHI/MFLO read path. A start/busy/done handshake lets the pipeline control stall dependent instructions.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

Ports:
clk  input  1  single clock; all state updates on rising edge
rstN  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy==0
funct  input  6  operation, using the ISA funct codes FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU, FUN_MTHI, FUN_MTLO
opA  input  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source)
opB  input  WIDTH  rt value (divisor / multiplier)
flush  input  1  abort in-flight op (exception); HI/LO unchanged
busy  output  1  operation in flight; pipeline stalls MFHI/MFLO/new mul-div while high
done  output  1  one-cycle pulse when HI/LO updated by MULT*/DIV*
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rstN low, async): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Mid-operation reset discards work.
- States: IDLE -> MUL | DIV (32 iterations) -> FIX -> IDLE.
- IDLE, start=1, funct=MTHI/MTLO: hi (or lo) <= opA at that edge. Single cycle, busy stays 0, done stays 0.
- IDLE, start=1, funct=MULT*/DIV*: latch |opA|, |opB| (signed ops) or raw values (unsigned). Latch result-sign flags and counter=0. Enter MUL/DIV. busy=1 from the next cycle.
- IDLE, start=1, unrecognised funct: ignored. In simulation, emit $warning if funct is not x.
- start while busy=1: ignored and never queued. Control must hold it.
- MUL: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per cycle, WIDTH-bit remainder.
- After iteration WIDTH-1, enter FIX:
  - Multiply: negate the 64-bit product if signs differ.
  - Divide: negate the quotient if sign(opA)^sign(opB); negate the remainder if sign(opA).
  - {hi,lo} <= product; or hi <= remainder, lo <= quotient.
  - done=1 for exactly one cycle, then busy=0 and return to IDLE.
- Latency: start accepted at edge E0. hi/lo written and done asserted at edge E(WIDTH+1), i.e. E33. busy is high for 33 cycles.
- Divide by zero (opB==0): completes with normal latency. Result: hi=opA (raw), lo=all ones. No exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
- flush=1: aborts any in-flight op the next edge. Return to IDLE, busy=0, no done, hi/lo preserved.
  - flush in IDLE is a no-op.
  - flush and start in the same IDLE cycle: flush wins and start is ignored.
- hi/lo only change on MTHI/MTLO or the FIX cycle.

Decomposition:
- Shared ISA package holds: FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU, FUN_MTHI, FUN_MTLO funct constants; state encoding constants (ST_IDLE, ST_MUL, ST_DIV, ST_FIX).
- One natural sub-module: mul_div_core. It holds the iterative shift-add/restoring datapath (accumulator, remainder, counter, step enable).
- mul_div_unit keeps the FSM, sign handling, handshake and HI/LO registers.

Test Plan:
- Reset with start=0 -> hi=0, lo=0, busy=0, done=0. Assert rstN low mid-DIV at cycle 10 -> busy=0 immediately, hi=lo=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001. MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> busy 33 cycles, hi=5, lo=0xFFFFFFFF. MTHI 0x1234 then MTLO 0x5678 -> hi/lo updated next edge, busy never high.
- Start MULT, pulse flush at cycle 12 -> busy=0 next cycle, no done, hi/lo keep prior values. A second start during busy -> ignored, result matches first op only.
